// File: rtl/lsu_pkg.sv
// lsu_pkg: shared size encodings, FSM states and alignment helper for the load/store unit
package lsu_pkg;
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;
    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WRITE, S_DONE} lsu_state_e;
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        return (size == SZ_HALF && off[0]) || (size == SZ_WORD && off != 2'b00);
    endfunction
endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: load lane extraction/extension and sub-word store merge on a 32-bit word
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [15:0] wdata_i,
    input  logic [1:0]  off_i,
    input  logic [1:0]  size_i,
    input  logic        sign_ext_i,
    output logic [31:0] load_o,
    output logic [31:0] merged_o
);
    logic [15:0] h;
    logic [7:0]  b;
    logic [31:0] mask;
    // Select the addressed lane for loads; for stores, replicate the new data across lanes and splice it in under a lane mask
    always_comb begin
        h = off_i[1] ? word_i[31:16] : word_i[15:0];
        b = off_i[0] ? h[15:8] : h[7:0];
        load_o = size_i == SZ_BYTE ? {{24{sign_ext_i & b[7]}}, b} :
                 size_i == SZ_HALF ? {{16{sign_ext_i & h[15]}}, h} : word_i;
        mask = size_i == SZ_BYTE ? 32'h0000_00FF << {off_i, 3'b000} : 32'h0000_FFFF << {off_i[1], 4'b0000};
        merged_o = (word_i & ~mask) | ((size_i == SZ_BYTE ? {4{wdata_i[7:0]}} : {2{wdata_i}}) & mask);
    end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: byte/half/word loads and stores onto a word-only memory, with read-modify-write for sub-word stores
module load_store_unit
    import lsu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        done,
    output logic        fault,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_write,
    input  logic [31:0] mem_rdata
);
    lsu_state_e  state_q;
    logic        we_q, sign_ext_q, fault_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q, wdata_q, merged_q, rdata_q;
    logic [31:0] load_val, merged;
    logic        bad;

    assign bad = is_misaligned(size, addr[1:0]) || size == SZ_ILL;

    lsu_lane_align u_align (
        .word_i     (mem_rdata),
        .wdata_i    (wdata_q[15:0]),
        .off_i      (addr_q[1:0]),
        .size_i     (size_q),
        .sign_ext_i (sign_ext_q),
        .load_o     (load_val),
        .merged_o   (merged)
    );

    // Request acceptance, access sequencing and result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            we_q       <= 1'b0;
            sign_ext_q <= 1'b0;
            fault_q    <= 1'b0;
            size_q     <= 2'b00;
            addr_q     <= '0;
            wdata_q    <= '0;
            merged_q   <= '0;
            rdata_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (req) begin
                        we_q       <= we;
                        size_q     <= size;
                        sign_ext_q <= sign_ext;
                        addr_q     <= addr;
                        wdata_q    <= wdata;
                        fault_q    <= bad;
                        state_q    <= bad ? S_DONE : S_ACCESS;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_ACCESS: begin
                    if (!we_q) rdata_q <= load_val;
                    merged_q <= merged;
                    state_q  <= (we_q && size_q != SZ_WORD) ? S_WRITE : S_DONE;
                end
                S_WRITE: state_q <= S_DONE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign rdata     = rdata_q;
    assign busy      = state_q == S_ACCESS || state_q == S_WRITE;
    assign done      = state_q == S_DONE;
    assign fault     = done && fault_q;
    assign mem_addr  = {addr_q[31:2], 2'b00};
    assign mem_wdata = state_q == S_WRITE ? merged_q : wdata_q;
    assign mem_write = !reset && ((state_q == S_ACCESS && we_q && size_q == SZ_WORD) || state_q == S_WRITE);
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed checks of loads, stores, faults, back-to-back and reset abort
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        reset, req, we, sign_ext, busy, done, fault, mem_write;
    logic [1:0]  size;
    logic [31:0] addr, wdata, rdata, mem_addr, mem_wdata, mem_rdata;
    logic [31:0] mem [0:63] = '{16: 32'h8899AABB, default: 32'h0};
    int          checks = 0;
    int          failures = 0;
    int          lat;
    logic [31:0] wmask;
    logic        flt, bsy1;

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[7:2]];
    always @(posedge clk) if (mem_write) mem[mem_addr[7:2]] <= mem_wdata;

    load_store_unit dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .size(size), .sign_ext(sign_ext),
        .addr(addr), .wdata(wdata), .rdata(rdata), .busy(busy), .done(done), .fault(fault),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write), .mem_rdata(mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_op(input logic w, input logic [1:0] s, input logic sx, input logic [31:0] a,
                         input logic [31:0] d, output int l, output logic [31:0] wm,
                         output logic f, output logic b1);
        req = 1'b1; we = w; size = s; sign_ext = sx; addr = a; wdata = d;
        @(posedge clk); #1;
        req = 1'b0;
        l = 0; wm = '0; f = 1'b0; b1 = busy;
        for (int c = 1; c <= 8; c++) begin
            if (mem_write) wm[c] = 1'b1;
            if (done) begin
                l = c;
                f = fault;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        reset = 1'b1; req = 1'b0; we = 1'b0; size = 2'b00; sign_ext = 1'b0; addr = '0; wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_done", {31'b0, done}, 32'h0);
        chk("rst_fault", {31'b0, fault}, 32'h0);
        chk("rst_mem_write", {31'b0, mem_write}, 32'h0);
        reset = 1'b0;
        @(posedge clk); #1;

        do_op(1'b0, 2'b00, 1'b1, 32'h42, 32'h0, lat, wmask, flt, bsy1);
        chk("lb_sx_rdata", rdata, 32'hFFFFFF99);
        chk("lb_sx_lat", lat, 32'd2);
        chk("lb_sx_busy", {31'b0, bsy1}, 32'h1);
        chk("lb_sx_nowrite", wmask, 32'h0);
        do_op(1'b0, 2'b00, 1'b0, 32'h42, 32'h0, lat, wmask, flt, bsy1);
        chk("lb_zx_rdata", rdata, 32'h00000099);
        do_op(1'b0, 2'b01, 1'b1, 32'h42, 32'h0, lat, wmask, flt, bsy1);
        chk("lh_sx_rdata", rdata, 32'hFFFF8899);
        chk("lh_sx_lat", lat, 32'd2);
        do_op(1'b0, 2'b01, 1'b0, 32'h40, 32'h0, lat, wmask, flt, bsy1);
        chk("lh_zx_rdata", rdata, 32'h0000AABB);

        do_op(1'b1, 2'b00, 1'b0, 32'h41, 32'h12345612, lat, wmask, flt, bsy1);
        chk("sb_mem", mem[16], 32'h889912BB);
        chk("sb_lat", lat, 32'd3);
        chk("sb_write_cycle", wmask, 32'h4);
        chk("sb_fault", {31'b0, flt}, 32'h0);
        chk("sb_rdata_kept", rdata, 32'h0000AABB);

        do_op(1'b1, 2'b10, 1'b0, 32'h41, 32'hCAFEF00D, lat, wmask, flt, bsy1);
        chk("sw_mis_fault", {31'b0, flt}, 32'h1);
        chk("sw_mis_lat", lat, 32'd1);
        chk("sw_mis_nowrite", wmask, 32'h0);
        do_op(1'b1, 2'b01, 1'b0, 32'h43, 32'hCAFEF00D, lat, wmask, flt, bsy1);
        chk("sh_mis_fault", {31'b0, flt}, 32'h1);
        chk("sh_mis_lat", lat, 32'd1);
        chk("sh_mis_nowrite", wmask, 32'h0);
        do_op(1'b0, 2'b11, 1'b1, 32'h40, 32'h0, lat, wmask, flt, bsy1);
        chk("ill_fault", {31'b0, flt}, 32'h1);
        chk("ill_lat", lat, 32'd1);
        chk("fault_mem_kept", mem[16], 32'h889912BB);
        chk("fault_rdata_kept", rdata, 32'h0000AABB);

        req = 1'b1; we = 1'b1; size = 2'b10; sign_ext = 1'b0; addr = 32'h44; wdata = 32'hDEADBEEF;
        @(posedge clk); #1;
        chk("b2b_sw_write", {31'b0, mem_write}, 32'h1);
        chk("b2b_sw_wdata", mem_wdata, 32'hDEADBEEF);
        we = 1'b0;
        @(posedge clk); #1;
        chk("b2b_sw_done", {31'b0, done}, 32'h1);
        chk("b2b_sw_fault", {31'b0, fault}, 32'h0);
        chk("b2b_sw_mem", mem[17], 32'hDEADBEEF);
        @(posedge clk); #1;
        req = 1'b0;
        chk("b2b_lw_busy", {31'b0, busy}, 32'h1);
        chk("b2b_lw_notdone", {31'b0, done}, 32'h0);
        @(posedge clk); #1;
        chk("b2b_lw_done", {31'b0, done}, 32'h1);
        chk("b2b_lw_rdata", rdata, 32'hDEADBEEF);
        @(posedge clk); #1;

        req = 1'b1; we = 1'b1; size = 2'b00; addr = 32'h40; wdata = 32'h00000077;
        @(posedge clk); #1;
        req = 1'b0;
        @(posedge clk); #1;
        chk("rmw_in_write", {31'b0, mem_write}, 32'h1);
        reset = 1'b1;
        #1;
        chk("rst_gates_write", {31'b0, mem_write}, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort_busy", {31'b0, busy}, 32'h0);
        chk("abort_done", {31'b0, done}, 32'h0);
        chk("abort_fault", {31'b0, fault}, 32'h0);
        chk("abort_rdata", rdata, 32'h0);
        chk("abort_mem_kept", mem[16], 32'h889912BB);
        @(posedge clk); #1;
        chk("abort_no_late_write", mem[16], 32'h889912BB);
        do_op(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, lat, wmask, flt, bsy1);
        chk("post_rst_lw_rdata", rdata, 32'h889912BB);
        chk("post_rst_lw_lat", lat, 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sits between the datapath and the byte-addressed little-endian data memory. Turns byte, halfword and word load/store requests into aligned 32-bit memory accesses. Sub-word stores become a read-modify-write sequence, because the memory only writes whole words. Also does load lane extraction with sign/zero extension, and flags misaligned or illegal requests without touching memory.

## Interface
Parameters:
- none. Size encodings and state encoding live in `lsu_pkg`.

Ports:
- clk  in  1  rising-edge clock, shared with memory
- reset  in  1  synchronous, active-high
- req  in  1  request strobe; accepted when req && !busy
- we  in  1  1 = store, 0 = load
- size  in  2  00 byte, 01 half, 10 word, 11 illegal
- sign_ext  in  1  loads only: 1 = sign-extend, 0 = zero-extend
- addr  in  32  byte address
- wdata  in  32  store data; low byte/half used for sub-word stores
- rdata  out  32  load result; held until the next successful load completes
- busy  out  1  high in ACCESS and WRITE
- done  out  1  one-cycle completion pulse
- fault  out  1  valid with done; misaligned or illegal size
- mem_addr  out  32  {addr_q[31:2], 2'b00}
- mem_wdata  out  32  word to write
- mem_write  out  1  memory write enable, gated by !reset
- mem_rdata  in  32  combinational memory read data for mem_addr

## Operation
- States: IDLE, ACCESS, WRITE, DONE.
- Acceptance (IDLE or DONE with req=1):
  - Latch we, size, sign_ext, addr and wdata.
  - Fault check: half requires addr[0]=0; word requires addr[1:0]=0; size=11 always faults.
  - Fault → go to DONE with fault_q=1. No memory access occurs.
  - Otherwise → go to ACCESS.
- ACCESS:
  - Load: extract the lane from mem_rdata.
    - Byte: mem_rdata[8*addr_q[1:0] +: 8].
    - Half: mem_rdata[16*addr_q[1] +: 16].
    - Word: full 32 bits.
    - Extend to 32 bits according to sign_ext, register into rdata, then go to DONE.
  - Word store: mem_write=1, mem_wdata=wdata_q, then go to DONE.
  - Sub-word store: register merged = mem_rdata with the target lane replaced by wdata_q[7:0] or [15:0], then go to WRITE.
- WRITE: mem_write=1, mem_wdata=merged, then go to DONE.
- DONE: done=1, and fault=fault_q.
  - req=1: accepted as in IDLE, giving back-to-back operation.
  - req=0: go to IDLE.
- IDLE, or DONE without req: mem_write=0 and mem_addr is don't-care.
- req while busy: ignored, not queued. The requester holds req until accepted.
- Faulting or store completion leaves rdata unchanged.
- mem_addr is always word-aligned. The upper address bits pass through unchanged; the memory truncates them.

## Timing
- Reset values: state IDLE; rdata 0; done 0; fault 0; busy 0; mem_write 0; internal registers 0.
- Latency from the accept edge (cycle 0):
  - Load and word store: done in cycle 2.
  - Sub-word store: done in cycle 3.
  - Fault: done in cycle 1.
- mem_write is asserted for exactly one cycle per non-faulting store; the write commits at the following edge.
- Throughput with a continuous req:
  - One load or word store per 2 cycles.
  - One sub-word store per 3 cycles.
- Reset in any state returns to IDLE at that edge.
  - mem_write is forced to 0 during the reset cycle, so an interrupted store never writes memory.
  - A pending done is dropped.
- The read-modify-write is not atomic against other memory writers. There are none in this design.

## Structure
- `lsu_pkg`:
  - Size constants SZ_BYTE/SZ_HALF/SZ_WORD/SZ_ILL.
  - State enum.
  - Function `is_misaligned(size, addr[1:0])`.
- Sub-module `lsu_lane_align` (combinational):
  - Load extract/extend: mem_rdata, addr[1:0], size, sign_ext → 32-bit result.
  - Store merge: old word, wdata, addr[1:0], size → merged word.
- The top level holds the FSM and registers.

## Test plan
Preload word 0x40 = 0x8899AABB (bytes 0x40=BB, 0x41=AA, 0x42=99, 0x43=88).
- Byte loads: lb at 0x42 with sign_ext=1 → rdata 0xFFFFFF99, done in cycle 2; repeat with sign_ext=0 → 0x00000099.
- Half loads: lh at 0x42 with sign_ext=1 → 0xFFFF8899; lh at 0x40 with sign_ext=0 → 0x0000AABB.
- Byte store: sb at 0x41 with wdata 0x12345612 → word 0x40 becomes 0x889912BB; mem_write high only in cycle 2; done in cycle 3.
- Faults: sw at 0x41, sh at 0x43 and size=11 → fault=1 with done in cycle 1; mem_write never asserted; memory and rdata unchanged.
- Back-to-back: req held for a sw to 0x44 (0xDEADBEEF) followed by lw from 0x44 → second request accepted in the DONE cycle of the first; rdata 0xDEADBEEF two cycles later.
- Reset mid-operation: reset asserted during WRITE of sb at 0x40 → no mem_write edge, word unchanged, all outputs at reset values next cycle, and a new req is accepted normally.
